// File: rtl/pc_sequencer.sv
// Program counter register and sequencer for the shared PC adder.
// The adder alternates between PC+2 and PC+2+offset; a taken relative branch costs one bubble.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          IMM_W    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [IMM_W-1:0] br_imm,
  input  logic             br_reg_taken,
  input  logic [15:0]      br_reg_val,
  input  logic             halt,
  output logic [15:0]      add_a,
  output logic [15:0]      add_b,
  input  logic [15:0]      add_sum,
  output logic [15:0]      pc,
  output logic [15:0]      pc_plus2,
  output logic             fetch_valid,
  output logic             busy,
  output logic             halted
);

  typedef enum logic [1:0] {RUN, TGT, HALT} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt, pc_plus2_nxt;
  logic [15:0] off, off_nxt;

  // Word offset to byte offset: sign-extend to 16 bits, then scale by 2.
  function automatic logic [15:0] word_to_byte_off(input logic signed [IMM_W-1:0] imm);
    return 16'(imm) << 1;
  endfunction

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pc_plus2_nxt = pc_plus2;
    off_nxt      = off;
    add_a        = pc;
    add_b        = 16'h0002;
    case (state)
      RUN: begin
        if (stall) begin
          state_nxt = RUN;
        end else if (halt) begin
          pc_plus2_nxt = add_sum;
          state_nxt    = HALT;
        end else if (br_reg_taken) begin
          pc_nxt       = br_reg_val;
          pc_plus2_nxt = add_sum;
        end else if (br_taken) begin
          pc_plus2_nxt = add_sum;
          off_nxt      = word_to_byte_off(br_imm);
          state_nxt    = TGT;
        end else begin
          pc_nxt       = add_sum;
          pc_plus2_nxt = add_sum;
        end
      end
      // The adder is borrowed for the target; pc_plus2 already holds the branch's PC+2.
      TGT: begin
        add_a     = pc_plus2;
        add_b     = off;
        pc_nxt    = add_sum;
        state_nxt = RUN;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      pc_plus2 <= 16'h0000;
      off      <= 16'h0000;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pc_plus2 <= pc_plus2_nxt;
      off      <= off_nxt;
    end
  end

  assign fetch_valid = (state == RUN);
  assign busy        = (state == TGT);
  assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random traffic,
// all compared against a behavioural model of the PC sequencing rules.
module tb_pc_sequencer;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall, br_taken, br_reg_taken, halt;
  logic [8:0]  br_imm;
  logic [15:0] br_reg_val;
  logic [15:0] add_a, add_b, add_sum, pc, pc_plus2;
  logic        fetch_valid, busy, halted;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0 = running, 1 = computing branch target, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc, m_pp2, m_off;
  bit          m_ok = 0;

  always #5 clk = ~clk;

  // Shared adder lives outside the block.
  assign add_sum = add_a + add_b;

  pc_sequencer #(.RESET_PC(RST_PC), .IMM_W(9)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
    .br_reg_taken(br_reg_taken), .br_reg_val(br_reg_val), .halt(halt),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .pc(pc), .pc_plus2(pc_plus2),
    .fetch_valid(fetch_valid), .busy(busy), .halted(halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int imm_s;
    if (rst) begin
      m_mode = 0; m_pc = RST_PC; m_pp2 = 16'h0000; m_off = 16'h0000;
    end else if (m_mode == 0) begin
      if (stall) begin
        m_mode = 0;
      end else if (halt) begin
        m_pp2 = m_pc + 16'd2; m_mode = 2;
      end else if (br_reg_taken) begin
        m_pp2 = m_pc + 16'd2; m_pc = br_reg_val;
      end else if (br_taken) begin
        imm_s = int'($signed(br_imm));
        m_pp2 = m_pc + 16'd2; m_off = 16'(imm_s * 2); m_mode = 1;
      end else begin
        m_pc = m_pc + 16'd2; m_pp2 = m_pc;
      end
    end else if (m_mode == 1) begin
      m_pc = m_pp2 + m_off; m_mode = 0;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic bt, input logic [8:0] imm,
                     input logic brt, input logic [15:0] brv, input logic h);
    rst = r; stall = s; br_taken = bt; br_imm = imm;
    br_reg_taken = brt; br_reg_val = brv; halt = h;
    #1;
    if (m_ok) begin
      chk("add_a", add_a, (m_mode == 1) ? m_pp2 : m_pc);
      chk("add_b", add_b, (m_mode == 1) ? m_off : 16'h0002);
    end
    @(posedge clk);
    model_step();
    m_ok = 1;
    #1;
    chk("pc", pc, m_pc);
    chk("pc_plus2", pc_plus2, m_pp2);
    chk("fetch_valid", 16'(fetch_valid), 16'(m_mode == 0));
    chk("busy", 16'(busy), 16'(m_mode == 1));
    chk("halted", 16'(halted), 16'(m_mode == 2));
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic jump(input logic [15:0] a);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, a, 1'b0);
  endtask

  initial begin
    logic [15:0] rv;
    // Reset and free-running increment
    do_reset();
    chk("rst_pc", pc, RST_PC);
    chk("rst_fv", 16'(fetch_valid), 16'h0001);
    for (int i = 0; i < 3; i++) idle();
    chk("free_pc", pc, 16'h0006);
    chk("free_pp2", pc_plus2, 16'h0006);

    // Forward relative branch
    jump(16'h0010);
    cyc(1'b0, 1'b0, 1'b1, 9'h004, 1'b0, 16'h0000, 1'b0);
    chk("tgt_busy", 16'(busy), 16'h0001);
    chk("tgt_add_a", add_a, 16'h0012);
    chk("tgt_add_b", add_b, 16'h0008);
    idle();
    chk("fwd_target", pc, 16'h001A);

    // Backward branch wrapping below zero, then increment wrap
    jump(16'h0004);
    cyc(1'b0, 1'b0, 1'b1, 9'h1FC, 1'b0, 16'h0000, 1'b0);
    idle();
    chk("back_target", pc, 16'hFFFE);
    idle();
    chk("inc_wrap", pc, 16'h0000);

    // Stall beats branch and halt; then halt takes effect and is absorbing
    jump(16'h0020);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 9'h010, 1'b0, 16'h0000, 1'b1);
    chk("stall_pc", pc, 16'h0020);
    cyc(1'b0, 1'b0, 1'b1, 9'h010, 1'b0, 16'h0000, 1'b1);
    chk("halt_pc", pc, 16'h0020);
    chk("halt_pp2", pc_plus2, 16'h0022);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 16'h0100, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 9'h003, 1'b0, 16'h0000, 1'b0);
    chk("halt_frozen", pc, 16'h0020);

    // Priority: register branch over relative branch, halt over register branch
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 9'h004, 1'b1, 16'h1234, 1'b0);
    chk("regbr_pc", pc, 16'h1234);
    chk("regbr_nobubble", 16'(busy), 16'h0000);
    cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b1, 16'h5678, 1'b1);
    chk("halt_wins", 16'(halted), 16'h0001);
    chk("halt_wins_pc", pc, 16'h1234);

    // Reset in HALT, then reset during a pending target
    do_reset();
    chk("rst_halt_pc", pc, RST_PC);
    jump(16'h0030);
    cyc(1'b0, 1'b0, 1'b1, 9'h007, 1'b0, 16'h0000, 1'b0);
    chk("pend_add_sum", add_sum, 16'h0040);
    do_reset();
    chk("rst_tgt_pc", pc, RST_PC);
    chk("rst_tgt_busy", 16'(busy), 16'h0000);
    idle();
    chk("tgt_discarded", pc, 16'h0002);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom) & 16'hFFFE;
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) == 0), 9'($urandom),
          ($urandom_range(0, 5) == 0), rv, ($urandom_range(0, 29) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
